cache_refill_responder: RTL and testbench

- Memory-side responder for the cache's block-refill and write-through interface. It is the peer the cache controller talks to when it misses or writes.
- Accepts one request at a time over a valid/ready handshake.
- A read returns the aligned 4-word (128-bit) block containing the requested word after a fixed modelled latency.
- A write commits one 32-bit word and is acknowledged with the same latency.

---
 rtl/refill_pkg.sv | 18 +
 rtl/refill_word_store.sv | 31 +++
 rtl/cache_refill_responder.sv | 113 +++++++++++
 tb/tb_cache_refill_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// Shared constants, FSM state type and block-alignment helper for the cache refill responder.
package refill_pkg;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_W     = 128;
  localparam int OFFSET_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Clears the word-offset bits so the result addresses word 0 of the enclosing block.
  function automatic logic [31:0] block_base(input logic [31:0] addr);
    return addr & ~32'(BLOCK_WORDS - 1);
  endfunction
endpackage

// File: rtl/refill_word_store.sv
// Word-addressed storage: one synchronous write port, one combinational aligned 4-word read port.
module refill_word_store
  import refill_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int INIT_ZERO = 1
) (
  input  logic                clock,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [BLOCK_W-1:0]  rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  // Power-up contents only; reset never touches the array.
  logic [WORD_W-1:0] mem [DEPTH] =
    '{default: (INIT_ZERO != 0) ? {WORD_W{1'b0}} : {WORD_W{1'bx}}};

  logic [ADDR_W-1:0] base;
  assign base = ADDR_W'(block_base(32'(raddr)));

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_rd
    assign rdata[i*WORD_W +: WORD_W] = mem[base | ADDR_W'(i)];
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side refill/write-through responder: one request in flight, fixed LATENCY to response.
// Optional macro REFILL_STATS_EN adds saturating read/write acceptance counters.
module cache_refill_responder
  import refill_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int LATENCY   = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_write,
  output logic [BLOCK_W-1:0]  resp_rdata,
`ifdef REFILL_STATS_EN
  output logic [15:0]         stat_reads,
  output logic [15:0]         stat_writes,
`endif
  output logic [1:0]          fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // req is taken only in IDLE, and resp_* hold stable from resp_valid rise until consumed.
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [BLOCK_W-1:0]  blk;
  logic                accept;

  assign accept    = (state == IDLE) && req_valid;
  assign fsm_state = state;

  refill_word_store #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_store (
    .clock (clock),
    .we    (accept && req_write),
    .waddr (req_addr),
    .wdata (req_wdata),
    .raddr (addr_q),
    .rdata (blk)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            cnt       <= LAT_INIT;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_write <= write_q;
            resp_rdata <= write_q ? '0 : blk;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef REFILL_STATS_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else if (accept) begin
      if (req_write) begin
        if (stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
      end else begin
        if (stat_reads != 16'hFFFF) stat_reads <= stat_reads + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_refill_responder.sv
// Directed self-checking bench for cache_refill_responder (define REFILL_STATS_EN for LATENCY=1 stats build).
module tb_cache_refill_responder;
  import refill_pkg::*;

  localparam int AW = 15;
`ifdef REFILL_STATS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  logic           clock = 1'b0;
  logic           rst;
  logic           req_valid, req_write, resp_ready;
  logic [AW-1:0]  req_addr;
  logic [31:0]    req_wdata;
  logic           req_ready, resp_valid, resp_write;
  logic [127:0]   resp_rdata;
  logic [1:0]     fsm_state;
`ifdef REFILL_STATS_EN
  logic [15:0]    stat_reads, stat_writes;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_reads  = 0;
  int exp_writes = 0;

  always #5 clock = ~clock;

  cache_refill_responder #(
    .ADDR_W    (AW),
    .LATENCY   (LAT),
    .INIT_ZERO (1)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
`ifdef REFILL_STATS_EN
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
`endif
    .fsm_state  (fsm_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; presents a request for one accepting edge, then scrambles req_*.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    check("issue_ready", 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0;
    req_addr  = AW'($urandom); req_wdata = $urandom;
    if (w) exp_writes++; else exp_reads++;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 40) begin
      @(posedge clock); #1; cyc++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
    int c;
    issue(1'b1, a, d);
    wait_resp(c);
    check("wr_latency", 128'(c), 128'(LAT));
    check("wr_resp_write", 128'(resp_write), 128'(1));
    check("wr_resp_rdata", resp_rdata, 128'h0);
    consume();
  endtask

  task automatic check_stats(input string tag);
`ifdef REFILL_STATS_EN
    check({tag, "_reads"}, 128'(stat_reads), 128'(exp_reads));
    check({tag, "_writes"}, 128'(stat_writes), 128'(exp_writes));
`else
    check({tag, "_idle_state"}, 128'(fsm_state), 128'(IDLE));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int seen;
    int pre_rst;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0;
    #2;
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_rdata", resp_rdata, 128'h0);
    check("rst_state", 128'(fsm_state), 128'(IDLE));
    @(posedge clock); #1; rst = 1'b0;
    @(posedge clock); #1;

    // Asynchronous reset asserted mid-cycle while a read response is pending.
    write_word(15'd5, 32'hCAFE_F00D);
    issue(1'b0, 15'd5, 32'h0);
    wait_resp(c);
    check("pre_rst_rdata", resp_rdata, 128'h0000_0000_0000_0000_CAFE_F00D_0000_0000);
    #2; rst = 1'b1; #1;
    check("async_rst_req_ready", 128'(req_ready), 128'(1));
    check("async_rst_resp_valid", 128'(resp_valid), 128'(0));
    check("async_rst_resp_rdata", resp_rdata, 128'h0);
    check("async_rst_state", 128'(fsm_state), 128'(IDLE));
    exp_reads = 0; exp_writes = 0;
    check_stats("stats_after_rst");
    @(posedge clock); #1; rst = 1'b0;

    // Write-through then block read of the same block.
    write_word(15'd1025, 32'hDEAD_BEEF);
    issue(1'b0, 15'd1027, 32'h0);
    wait_resp(c);
    check("rd_latency", 128'(c), 128'(LAT));
    check("rd_word1", 128'(resp_rdata[63:32]), 128'(32'hDEAD_BEEF));
    check("rd_resp_write", 128'(resp_write), 128'(0));
    consume();

    // Backpressure: response must hold while resp_ready stays low.
    write_word(15'd185, 32'hA5A5_0185);
    issue(1'b0, 15'd185, 32'h0);
    wait_resp(c);
    check("bp_latency", 128'(c), 128'(LAT));
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("bp_hold_valid", 128'(resp_valid), 128'(1));
      check("bp_hold_rdata", resp_rdata, 128'h0000_0000_0000_0000_A5A5_0185_0000_0000);
      check("bp_hold_write", 128'(resp_write), 128'(0));
    end
    consume();
    check("bp_valid_drop", 128'(resp_valid), 128'(0));
    check("bp_ready_back", 128'(req_ready), 128'(1));

    // Top-of-storage block.
    write_word(15'd32764, 32'h1111_1111);
    write_word(15'd32765, 32'h2222_2222);
    write_word(15'd32766, 32'h3333_3333);
    write_word(15'd32767, 32'h4444_4444);
    issue(1'b0, 15'd32766, 32'h0);
    wait_resp(c);
    check("top_block", resp_rdata, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    consume();

    // Reset while the write ack is in flight: write stays committed, no response.
    issue(1'b1, 15'd200, 32'h0000_0005);
    pre_rst = (LAT >= 3) ? 1 : 0;
    repeat (pre_rst) begin @(posedge clock); #1; end
    rst = 1'b1; #1;
    check("abort_resp_valid", 128'(resp_valid), 128'(0));
    check("abort_state", 128'(fsm_state), 128'(IDLE));
    exp_reads = 0; exp_writes = 0;
    @(posedge clock); #1; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clock); #1;
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 128'(seen), 128'(0));
    issue(1'b0, 15'd200, 32'h0);
    wait_resp(c);
    check("abort_write_kept", resp_rdata, 128'h0000_0000_0000_0000_0000_0000_0000_0005);
    consume();

    // req_valid held through WAIT/RESP and the consume edge: taken exactly once.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'd300;
    @(posedge clock); #1;
    exp_reads++;
    wait_resp(c);
    check("held_latency", 128'(c), 128'(LAT));
    consume();
    req_valid = 1'b0;
    check("held_ready_after", 128'(req_ready), 128'(1));
    @(posedge clock); #1;
    check("held_not_reaccepted", 128'(fsm_state), 128'(IDLE));
    check("held_no_resp", 128'(resp_valid), 128'(0));

    write_word(15'd400, 32'h0000_0001);
    write_word(15'd401, 32'h0000_0002);
    issue(1'b0, 15'd400, 32'h0);
    wait_resp(c);
    check("final_block", resp_rdata, 128'h0000_0000_0000_0000_0000_0002_0000_0001);
    consume();
    check_stats("stats_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
